// File: rtl/aes_pkg.sv
// Shared AES primitives, key-length encodings and controller state codes.
// The S-box is computed from the GF(2^8) inverse and affine map, not stored as a table.
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128 = 2'd0;
    localparam logic [1:0] KEY_LEN_192 = 2'd1;
    localparam logic [1:0] KEY_LEN_256 = 2'd2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_KEYEXP = 2'd1;
    localparam logic [1:0] ST_ROUND  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    function automatic int calc_max_nr(input int max_nk);
        return max_nk + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Inverse as b^254 (b^2 * b^4 * ... * b^128); zero maps to zero.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] inv;
        p   = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox(s[8*k +: 8]);
        return o;
    endfunction

    // Byte k = 4*col + row sits at bits [127-8k -: 8].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] rk);
        return s ^ rk;
    endfunction

    function automatic logic [127:0] encrypt_round(input logic [127:0] s, input logic [127:0] rk);
        return add_round_key(mix_columns(shift_rows(sub_bytes(s))), rk);
    endfunction

    function automatic logic [127:0] final_round(input logic [127:0] s, input logic [127:0] rk);
        return add_round_key(shift_rows(sub_bytes(s)), rk);
    endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// Combinational key-schedule step: next word w[i] from w[i-1], w[i-Nk], i and Nk.
module aes_key_word_gen
    import aes_pkg::*;
#(
    parameter int IW = 6
) (
    input  logic [31:0]   prev,
    input  logic [31:0]   wnk,
    input  logic [IW-1:0] idx,
    input  logic [3:0]    nk,
    output logic [31:0]   word
);

    localparam logic [IW-1:0] SIX = IW'(6);

    logic [IW-1:0] pos;
    logic [3:0]    quo;
    logic [31:0]   temp;

    // Each legal Nk gets its own constant divisor so no general divider is built.
    always_comb begin
        pos = '0;
        quo = '0;
        case (nk)
            4'd4: begin pos = idx & IW'(3); quo = 4'(idx >> 2);  end
            4'd6: begin pos = idx % SIX;    quo = 4'(idx / SIX); end
            4'd8: begin pos = idx & IW'(7); quo = 4'(idx >> 3);  end
            default: ;
        endcase
    end

    always_comb begin
        temp = prev;
        if (pos == '0)
            temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(quo), 24'h0};
        else if (nk == 4'd8 && pos == IW'(4))
            temp = sub_word(prev);
        word = wnk ^ temp;
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor: cached key schedule, one round per clock,
// valid/ready streaming on plaintext and ciphertext sides.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | waiting for key_load or a plaintext block
//  ST_KEYEXP | expanding one schedule word per cycle into the key store
//  ST_ROUND  | applying round rnd_q to blk_q
//  ST_DONE   | holding ciphertext until out_ready
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key_in,
    input  logic [1:0]   key_len,
    input  logic         key_load,
    output logic         key_ready,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int         MAX_NR   = calc_max_nr(MAX_NK);
    localparam int         NW       = 4 * (MAX_NR + 1);
    localparam int         IW       = $clog2(NW);
    localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

    logic [1:0]    state_q;
    logic [3:0]    nk_q, nr_q, rnd_q;
    logic [IW-1:0] widx_q;
    logic [127:0]  blk_q;
    logic [31:0]   w_mem [NW];

    logic [3:0]    nk_req;
    logic          key_ok, load_acc, blk_acc, last_word;
    logic [IW-1:0] rk_base;
    logic [127:0]  rk, rk0;
    logic [31:0]   prev_w, wnk_w, new_w;

    always_comb begin
        case (key_len)
            KEY_LEN_128: nk_req = 4'd4;
            KEY_LEN_192: nk_req = 4'd6;
            KEY_LEN_256: nk_req = 4'd8;
            default:     nk_req = 4'd0;
        endcase
    end

    assign key_ok    = (nk_req != 4'd0) && (nk_req <= MAX_NK_W);
    assign load_acc  = (state_q == ST_IDLE) && key_load && key_ok;
    assign in_ready  = (state_q == ST_IDLE) && key_ready && !key_load;
    assign blk_acc   = in_valid && in_ready;
    assign last_word = (widx_q == IW'({nr_q, 2'b11}));

    assign rk_base = IW'({rnd_q, 2'b00});
    assign rk      = {w_mem[rk_base], w_mem[rk_base + IW'(1)],
                      w_mem[rk_base + IW'(2)], w_mem[rk_base + IW'(3)]};
    assign rk0     = {w_mem[0], w_mem[1], w_mem[2], w_mem[3]};
    assign prev_w  = w_mem[widx_q - IW'(1)];
    assign wnk_w   = w_mem[widx_q - IW'(nk_q)];

    aes_key_word_gen #(.IW(IW)) u_kwg (
        .prev (prev_w),
        .wnk  (wnk_w),
        .idx  (widx_q),
        .nk   (nk_q),
        .word (new_w)
    );

    // Key store keeps its contents through reset; key_ready alone marks it stale.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (load_acc) begin
                for (int j = 0; j < MAX_NK; j++)
                    if (4'(j) < nk_req) w_mem[j] <= key_in[255-32*j -: 32];
            end else if (state_q == ST_KEYEXP) begin
                w_mem[widx_q] <= new_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            key_ready <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            blk_q     <= '0;
            nk_q      <= '0;
            nr_q      <= '0;
            rnd_q     <= '0;
            widx_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_acc) begin
                        nk_q      <= nk_req;
                        nr_q      <= nk_req + 4'd6;
                        widx_q    <= IW'(nk_req);
                        key_ready <= 1'b0;
                        state_q   <= ST_KEYEXP;
                    end else if (blk_acc) begin
                        blk_q   <= add_round_key(in_data, rk0);
                        rnd_q   <= 4'd1;
                        state_q <= ST_ROUND;
                    end
                end
                ST_KEYEXP: begin
                    if (last_word) begin
                        widx_q    <= '0;
                        key_ready <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        widx_q <= widx_q + IW'(1);
                    end
                end
                ST_ROUND: begin
                    if (rnd_q == nr_q) begin
                        out_data  <= final_round(blk_q, rk);
                        out_valid <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        blk_q <= encrypt_round(blk_q, rk);
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rnd_q     <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 vectors, random keys/blocks
// against a byte-array AES model, backpressure, key priority and reset abort.
module tb_aes_encrypt_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key_in;
    logic [1:0]   key_len;
    logic         key_load;
    logic         key_ready;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;

    int n_chk = 0;
    int n_bad = 0;
    logic [7:0] sbt [256];

    always #5 clk = ~clk;

    aes_encrypt_iter #(.MAX_NK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_len   (key_len),
        .key_load  (key_load),
        .key_ready (key_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic       hi;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
        end
        return p;
    endfunction

    // Inverse by exhaustive search, then the bitwise affine map.
    task automatic build_sbox;
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbt[x] = s;
        end
    endtask

    function automatic logic [31:0] m_subw(input logic [31:0] w);
        return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
    endfunction

    function automatic logic [127:0] ref_enc(input logic [255:0] key, input int nk, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [7:0]   rc;
        logic [31:0]  tw;
        logic [127:0] ct;
        int           nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tw = w[i-1];
            if (i % nk == 0) begin
                tw = m_subw({tw[23:0], tw[31:24]}) ^ {rc, 24'h0};
                rc = m_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tw = m_subw(tw);
            end
            w[i] = w[i-nk] ^ tw;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int k = 0; k < 16; k++) s[k] = sbt[s[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int k = 0; k < 16; k++) s[k] = t[k];
            if (rd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
                    s[4*c+0] = m_mul(a[0], 8'h02) ^ m_mul(a[1], 8'h03) ^ a[2] ^ a[3];
                    s[4*c+1] = a[0] ^ m_mul(a[1], 8'h02) ^ m_mul(a[2], 8'h03) ^ a[3];
                    s[4*c+2] = a[0] ^ a[1] ^ m_mul(a[2], 8'h02) ^ m_mul(a[3], 8'h03);
                    s[4*c+3] = m_mul(a[0], 8'h03) ^ a[1] ^ a[2] ^ m_mul(a[3], 8'h02);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*rd + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) ct[127-8*k -: 8] = s[k];
        return ct;
    endfunction

    task automatic load_key(input logic [255:0] k, input logic [1:0] len, output int cyc);
        key_in   = k;
        key_len  = len;
        key_load = 1'b1;
        step;
        key_load = 1'b0;
        chk("key_ready_clear", 256'(key_ready), 256'(1'b0));
        cyc = 0;
        while (!key_ready && cyc < 200) begin
            step;
            cyc++;
        end
    endtask

    task automatic run_block(input logic [127:0] d, input int stall,
                             output logic [127:0] ct, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            step;
            w++;
        end
        chk("in_ready_wait", 256'(in_ready), 256'(1'b1));
        in_data  = d;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            step;
            lat++;
        end
        ct = out_data;
        repeat (stall) step;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [255:0] k1, k2, k3, kr;
        logic [127:0] pt, ct, rp, held;
        logic [1:0]   len;
        logic         seen;
        int           cyc, lat, nk;

        k1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        k2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        k3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        pt = 128'h00112233445566778899aabbccddeeff;

        rst_n = 1'b0; key_in = '0; key_len = 2'd0; key_load = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        build_sbox;
        repeat (2) step;
        chk("rst_key_ready", 256'(key_ready), 256'(1'b0));
        chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
        chk("rst_out_data", 256'(out_data), 256'(128'h0));
        chk("rst_in_ready", 256'(in_ready), 256'(1'b0));
        rst_n = 1'b1;
        step;

        load_key(k1, 2'd0, cyc);
        chk("c1_keyexp_cyc", 256'(cyc), 256'(40));
        run_block(pt, 0, ct, lat);
        chk("c1_ct", 256'(ct), 256'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
        chk("c1_lat", 256'(lat), 256'(10));

        load_key(k2, 2'd1, cyc);
        chk("c2_keyexp_cyc", 256'(cyc), 256'(46));
        run_block(pt, 1, ct, lat);
        chk("c2_ct", 256'(ct), 256'(128'hdda97ca4864cdfe06eaf70a0ec0d7191));
        chk("c2_lat", 256'(lat), 256'(12));

        load_key(k3, 2'd2, cyc);
        chk("c3_keyexp_cyc", 256'(cyc), 256'(52));
        run_block(pt, 2, ct, lat);
        chk("c3_ct", 256'(ct), 256'(128'h8ea2b7ca516745bfeafc49904b496089));
        chk("c3_lat", 256'(lat), 256'(14));

        for (int t = 0; t < 4; t++) begin
            len = 2'($urandom_range(0, 2));
            nk  = 4 + 2 * int'(len);
            kr  = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            load_key(kr, len, cyc);
            chk("rnd_keyexp_cyc", 256'(cyc), 256'(3 * nk + 28));
            for (int b = 0; b < 3; b++) begin
                rp = {$urandom(), $urandom(), $urandom(), $urandom()};
                run_block(rp, int'($urandom_range(0, 3)), ct, lat);
                chk("rnd_ct", 256'(ct), 256'(ref_enc(kr, nk, rp)));
                chk("rnd_lat", 256'(lat), 256'(nk + 6));
            end
        end

        load_key(k1, 2'd0, cyc);
        chk("bp_keyexp_cyc", 256'(cyc), 256'(40));
        in_data = pt; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            step;
            lat++;
        end
        held = out_data;
        chk("bp_ct", 256'(held), 256'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
        for (int i = 0; i < 20; i++) begin
            step;
            chk("bp_hold_data", 256'(out_data), 256'(held));
            chk("bp_hold_valid", 256'(out_valid), 256'(1'b1));
            chk("bp_in_ready", 256'(in_ready), 256'(1'b0));
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk("bp_release_valid", 256'(out_valid), 256'(1'b0));
        chk("bp_release_in_ready", 256'(in_ready), 256'(1'b1));
        rp = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_block(rp, 0, ct, lat);
        chk("bp_next_ct", 256'(ct), 256'(ref_enc(k1, 4, rp)));

        key_in = k1; key_len = 2'd0; key_load = 1'b1;
        in_data = {$urandom(), $urandom(), $urandom(), $urandom()}; in_valid = 1'b1;
        #1;
        chk("prio_in_ready", 256'(in_ready), 256'(1'b0));
        step;
        key_load = 1'b0; in_valid = 1'b0;
        chk("prio_key_ready", 256'(key_ready), 256'(1'b0));
        cyc = 0;
        while (!key_ready && cyc < 200) begin
            step;
            cyc++;
        end
        chk("prio_keyexp_cyc", 256'(cyc), 256'(40));
        chk("prio_no_output", 256'(out_valid), 256'(1'b0));
        run_block(pt, 0, ct, lat);
        chk("prio_ct", 256'(ct), 256'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));

        key_in = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
        key_len = 2'd3; key_load = 1'b1;
        step;
        key_load = 1'b0; key_len = 2'd0;
        chk("len3_key_ready", 256'(key_ready), 256'(1'b1));
        step;
        chk("len3_in_ready", 256'(in_ready), 256'(1'b1));
        run_block(pt, 0, ct, lat);
        chk("len3_ct", 256'(ct), 256'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));

        in_data = pt; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        repeat (4) step;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        chk("abort_key_ready", 256'(key_ready), 256'(1'b0));
        chk("abort_out_valid", 256'(out_valid), 256'(1'b0));
        seen = 1'b0;
        repeat (20) begin
            step;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_output", 256'(seen), 256'(1'b0));
        chk("abort_in_ready", 256'(in_ready), 256'(1'b0));
        load_key(k1, 2'd0, cyc);
        chk("abort_keyexp_cyc", 256'(cyc), 256'(40));
        run_block(pt, 0, ct, lat);
        chk("abort_ct", 256'(ct), 256'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
        chk("abort_lat", 256'(lat), 256'(10));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
